// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared state encodings and port IDs for the memory arbiter
package memory_arbiter_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Requester port IDs: p0 = instruction cache, p1 = data cache
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int NUM_PORTS = 2;

  // One-hot grant vector for a port index
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// rtl/memory_arbiter_rr_picker.sv - combinational 2-input round-robin selector
module rr_picker
  import memory_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // On a tie the port that did not win last time goes first; a lone requester always wins.
  always_comb begin
    grant_idx = P0;
    grant     = 2'b00;
    if (&valid) begin
      grant_idx = ~last_grant;
    end else if (valid[1]) begin
      grant_idx = P1;
    end else begin
      grant_idx = P0;
    end
    if (|valid) begin
      grant = port_onehot(grant_idx);
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-port round-robin arbiter onto a single-outstanding memory port
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,

  // p0: instruction cache
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_write,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [LINE_W-1:0] p0_req_wdata,
  output logic              p0_resp_valid,
  output logic [LINE_W-1:0] p0_resp_rdata,

  // p1: data cache
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_write,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [LINE_W-1:0] p1_req_wdata,
  output logic              p1_resp_valid,
  output logic [LINE_W-1:0] p1_resp_rdata,

  // memory side
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_rdata,

  // status
  output logic              busy,
  output logic              proto_err,
  output logic [CNT_W-1:0]  p0_grant_cnt,
  output logic [CNT_W-1:0]  p1_grant_cnt
);

  logic [1:0]        state_q;
  logic              last_grant_q;
  logic              owner_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [CNT_W-1:0]  p0_cnt_q;
  logic [CNT_W-1:0]  p1_cnt_q;
  logic              proto_err_q;

  logic [1:0]        req_valid;
  logic [1:0]        grant;
  logic              grant_idx;
  logic              in_idle;
  logic              accept;
  logic              resp_fire;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;

  assign req_valid = {p1_req_valid, p0_req_valid};

  rr_picker u_picker (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Ready only toward the winner and only while idle; reset masks every handshake.
  assign in_idle      = (state_q == ST_IDLE) && !reset;
  assign p0_req_ready = in_idle && grant[0];
  assign p1_req_ready = in_idle && grant[1];
  assign accept       = in_idle && (|grant);

  // Request fields of whichever port is being granted this cycle
  assign sel_write = (grant_idx == P1) ? p1_req_write : p0_req_write;
  assign sel_addr  = (grant_idx == P1) ? p1_req_addr  : p0_req_addr;
  assign sel_wdata = (grant_idx == P1) ? p1_req_wdata : p0_req_wdata;

  // The memory only ever sees the latched copy, so it stays stable through back-pressure.
  assign mem_req_valid = (state_q == ST_ISSUE) && !reset;
  assign mem_req_write = write_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;

  // A response is only routed while a transaction is outstanding, and only to its owner.
  assign resp_fire     = (state_q == ST_WAIT) && mem_resp_valid && !reset;
  assign p0_resp_valid = resp_fire && (owner_q == P0);
  assign p1_resp_valid = resp_fire && (owner_q == P1);
  assign p0_resp_rdata = p0_resp_valid ? mem_resp_rdata : '0;
  assign p1_resp_rdata = p1_resp_valid ? mem_resp_rdata : '0;

  assign busy         = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign proto_err    = proto_err_q;
  assign p0_grant_cnt = p0_cnt_q;
  assign p1_grant_cnt = p1_cnt_q;

  // Transaction FSM: latch the winner on accept, hold it through issue, release on response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= P1;
      owner_q      <= P0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q <= grant_idx;
            write_q <= sel_write;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_req_ready) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            last_grant_q <= owner_q;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-port grant counters, saturating so a long run never wraps back to a small value.
  always_ff @(posedge clk) begin
    if (reset) begin
      p0_cnt_q <= '0;
      p1_cnt_q <= '0;
    end else if (accept) begin
      if (grant_idx == P0) begin
        if (p0_cnt_q != {CNT_W{1'b1}}) begin
          p0_cnt_q <= p0_cnt_q + 1'b1;
        end
      end else begin
        if (p1_cnt_q != {CNT_W{1'b1}}) begin
          p1_cnt_q <= p1_cnt_q + 1'b1;
        end
      end
    end
  end

  // Sticky flag for a memory response that arrives when nothing is outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err_q <= 1'b0;
    end else if (mem_resp_valid && (state_q != ST_WAIT)) begin
      proto_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - randomized self-checking bench for memory_arbiter
module tb_memory_arbiter;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 128;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              p0_req_valid = 1'b0, p0_req_write = 1'b0;
  logic [ADDR_W-1:0] p0_req_addr = '0;
  logic [LINE_W-1:0] p0_req_wdata = '0;
  logic              p1_req_valid = 1'b0, p1_req_write = 1'b0;
  logic [ADDR_W-1:0] p1_req_addr = '0;
  logic [LINE_W-1:0] p1_req_wdata = '0;
  logic              mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [LINE_W-1:0] mem_resp_rdata = '0;
  logic              p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid;
  logic [LINE_W-1:0] p0_resp_rdata, p1_resp_rdata, mem_req_wdata;
  logic              mem_req_valid, mem_req_write, busy, proto_err;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [CNT_W-1:0]  p0_grant_cnt, p1_grant_cnt;

  memory_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .busy(busy), .proto_err(proto_err), .p0_grant_cnt(p0_grant_cnt), .p1_grant_cnt(p1_grant_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model state: transaction-level view of the arbiter
  int m_last;
  int m_cnt [2];
  bit m_proto;

  // Observed handshake / response tallies
  int acc0 = 0, acc1 = 0, rsp0 = 0, rsp1 = 0;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input bit v0, input bit v1, input int last);
    if (v0 && v1) return (last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Let combinational outputs settle after the inputs change, then tally handshakes.
  task automatic sample();
    #1;
    if (p0_req_valid && p0_req_ready) acc0++;
    if (p1_req_valid && p1_req_ready) acc1++;
    if (p0_resp_valid) rsp0++;
    if (p1_resp_valid) rsp1++;
  endtask

  task automatic clear_inputs();
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0; m_proto = 1'b0;
  endtask

  // One full transaction: present requests, back-pressure the issue, delay the response.
  task automatic do_txn(input bit v0, input bit v1, input bit wr0, input bit wr1,
                        input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                        input logic [LINE_W-1:0] d0, input logic [LINE_W-1:0] d1,
                        input int stall, input int delay, input logic [LINE_W-1:0] rdata,
                        input bit hold_loser, output int granted);
    int w;
    bit exp_wr;
    logic [ADDR_W-1:0] exp_a;
    logic [LINE_W-1:0] exp_d;
    w = pick(v0, v1, m_last);
    exp_wr = (w == 1) ? wr1 : wr0;
    exp_a  = (w == 1) ? a1 : a0;
    exp_d  = (w == 1) ? d1 : d0;

    @(negedge clk);
    p0_req_valid = v0; p0_req_write = wr0; p0_req_addr = a0; p0_req_wdata = d0;
    p1_req_valid = v1; p1_req_write = wr1; p1_req_addr = a1; p1_req_wdata = d1;
    sample();
    granted = p1_req_ready ? 1 : (p0_req_ready ? 0 : -1);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("p0_ready", p0_req_ready, w == 0);
    check_eq("p1_ready", p1_req_ready, w == 1);
    if (m_cnt[w] < CNT_MAX) m_cnt[w]++;

    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      if (w == 0 || !hold_loser) p0_req_valid = 1'b0;
      if (w == 1 || !hold_loser) p1_req_valid = 1'b0;
      mem_req_ready = (i == stall);
      sample();
      check_eq("issue_valid", mem_req_valid, 1'b1);
      check_eq("issue_write", mem_req_write, exp_wr);
      check_eq("issue_addr", mem_req_addr, exp_a);
      check_eq("issue_wdata", mem_req_wdata, exp_d);
      check_eq("issue_ready", {p1_req_ready, p0_req_ready}, 2'b00);
      check_eq("issue_busy", busy, 1'b1);
    end

    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_resp_valid = (i == delay);
      mem_resp_rdata = (i == delay) ? rdata : {$urandom(), $urandom(), $urandom(), $urandom()};
      sample();
      check_eq("wait_memvalid", mem_req_valid, 1'b0);
      check_eq("wait_busy", busy, 1'b1);
      check_eq("wait_ready", {p1_req_ready, p0_req_ready}, 2'b00);
      check_eq("p0_resp_valid", p0_resp_valid, (i == delay) && (w == 0));
      check_eq("p1_resp_valid", p1_resp_valid, (i == delay) && (w == 1));
      if (i == delay && !exp_wr) begin
        check_eq("resp_rdata", (w == 1) ? p1_resp_rdata : p0_resp_rdata, rdata);
      end
    end
    m_last = w;

    @(negedge clk);
    clear_inputs();
    sample();
    check_eq("after_busy", busy, 1'b0);
    check_eq("p0_cnt", p0_grant_cnt, m_cnt[0]);
    check_eq("p1_cnt", p1_grant_cnt, m_cnt[1]);
    check_eq("proto_err", proto_err, m_proto);
  endtask

  initial begin
    int g;
    int a0s, a1s, r0s, r1s;
    int order [4];
    logic [LINE_W-1:0] deadbeef;
    order = '{0, 1, 0, 1};
    deadbeef = 128'hDEADBEEF_00C0FFEE_12345678_9ABCDEF0;

    do_reset();
    sample();
    check_eq("rst_ready", {p1_req_ready, p0_req_ready}, 2'b00);
    check_eq("rst_resp", {p1_resp_valid, p0_resp_valid}, 2'b00);
    check_eq("rst_rdata", p0_resp_rdata | p1_resp_rdata, '0);
    check_eq("rst_memvalid", mem_req_valid, 1'b0);
    check_eq("rst_memaddr", mem_req_addr, '0);
    check_eq("rst_memwdata", mem_req_wdata, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_proto", proto_err, 1'b0);
    check_eq("rst_cnt", {p1_grant_cnt, p0_grant_cnt}, '0);

    // Simultaneous requests straight after reset alternate starting with p0
    for (int k = 0; k < 4; k++) begin
      do_txn(1, 1, 0, 1, 32'h1000 + k, 32'h2000 + k, '0, 128'h55 + k, k % 3, 0, 128'hA0 + k, 1, g);
      check_eq("rr_order", g, order[k]);
    end
    check_eq("rr_p0_cnt", p0_grant_cnt, 16'd2);
    check_eq("rr_p1_cnt", p1_grant_cnt, 16'd2);

    // Lone p0 read, memory answers three cycles after issue
    do_reset();
    r0s = rsp0; r1s = rsp1;
    do_txn(1, 0, 0, 0, 32'h100, '0, '0, '0, 0, 3, deadbeef, 0, g);
    check_eq("p0_read_pulses", rsp0 - r0s, 1);
    check_eq("p0_read_p1_quiet", rsp1 - r1s, 0);
    check_eq("p0_read_cnt", p0_grant_cnt, 16'd1);

    // p1 write under five cycles of back-pressure
    a0s = acc0; a1s = acc1; r1s = rsp1;
    do_txn(0, 1, 0, 1, '0, 32'h40, '0, 128'h1234, 5, 0, '0, 0, g);
    check_eq("wr_accepts_p1", acc1 - a1s, 1);
    check_eq("wr_accepts_p0", acc0 - a0s, 0);
    check_eq("wr_ack_pulse", rsp1 - r1s, 1);

    // Stray memory response while idle
    r0s = rsp0; r1s = rsp1;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    sample();
    check_eq("stray_resp", {p1_resp_valid, p0_resp_valid}, 2'b00);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    sample();
    check_eq("stray_proto", proto_err, 1'b1);
    m_proto = 1'b1;
    do_txn(0, 1, 0, 0, '0, 32'h80, '0, '0, 1, 1, 128'hBEEF, 0, g);
    repeat (3) @(negedge clk);
    sample();
    check_eq("proto_sticky", proto_err, 1'b1);
    check_eq("stray_no_extra", (rsp0 - r0s) + (rsp1 - r1s), 1);

    // Reset while the transaction waits for its response
    r0s = rsp0; r1s = rsp1;
    @(negedge clk);
    p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = 32'h300;
    sample();
    check_eq("rstw_accept", p0_req_ready, 1'b1);
    @(negedge clk);
    p0_req_valid = 1'b0; mem_req_ready = 1'b1;
    sample();
    check_eq("rstw_issue", mem_req_valid, 1'b1);
    @(negedge clk);
    mem_req_ready = 1'b0;
    reset = 1'b1;
    sample();
    check_eq("rstw_no_resp", {p1_resp_valid, p0_resp_valid}, 2'b00);
    do_reset();
    sample();
    check_eq("rstw_idle", busy, 1'b0);
    check_eq("rstw_cnt", {p1_grant_cnt, p0_grant_cnt}, '0);
    check_eq("rstw_proto", proto_err, 1'b0);
    check_eq("rstw_resp_count", (rsp0 - r0s) + (rsp1 - r1s), 0);
    do_txn(1, 0, 0, 0, 32'h304, '0, '0, '0, 0, 0, 128'hC0DE, 0, g);
    check_eq("rstw_next_grant", g, 0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      bit v0, v1;
      int before0, before1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) begin
        @(negedge clk);
        clear_inputs();
        sample();
        check_eq("rnd_idle_ready", {p1_req_ready, p0_req_ready}, 2'b00);
        check_eq("rnd_idle_busy", busy, 1'b0);
        continue;
      end
      before0 = rsp0; before1 = rsp1;
      do_txn(v0, v1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom(), $urandom(),
             {$urandom(), $urandom(), $urandom(), $urandom()},
             {$urandom(), $urandom(), $urandom(), $urandom()},
             $urandom_range(0, 3), $urandom_range(0, 3),
             {$urandom(), $urandom(), $urandom(), $urandom()},
             1'($urandom_range(0, 1)), g);
      check_eq("rnd_one_resp", (rsp0 - before0) + (rsp1 - before1), 1);
    end

    // Counter saturation: start p0 at all-ones and grant once more
    @(negedge clk);
    force dut.p0_cnt_q = {CNT_W{1'b1}};
    @(negedge clk);
    release dut.p0_cnt_q;
    m_cnt[0] = CNT_MAX;
    sample();
    check_eq("sat_preload", p0_grant_cnt, 16'hFFFF);
    do_txn(1, 0, 0, 0, 32'h500, '0, '0, '0, 0, 0, 128'h77, 0, g);
    check_eq("sat_hold", p0_grant_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
